// File: rtl/vga_fb_display.sv
// vga_fb_display
//   Pixel back-end downstream of vga_sync. Prefetches framebuffer pixels into a
//   small FIFO through an in-order read port, pops one pixel per visible beam
//   cycle, and drives registered RGB plus delayed syncs. The fetch address and
//   FIFO are re-aligned on every vsync falling edge.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   WAIT_FRAME  | after reset, no fetching until the first vsync falling edge
//   RUN         | fetching and displaying; each vsync falling edge re-aligns
//
// Ports
//   clk, reset                 pixel clock, async active-low reset
//   visible, hsync, vsync      beam timing from vga_sync (syncs active low)
//   rd_req/rd_addr/rd_ready    framebuffer request channel (valid/ready)
//   rd_data_valid/rd_data      in-order responses {r,g,b}
//   vga_red/green/blue         registered colour, 0 when blanked
//   vga_hsync/vga_vsync        syncs delayed one cycle to match colour
//   underflow                  sticky per frame: visible pixel met empty FIFO
module vga_fb_display #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int ADDR_BITS  = 19,
  parameter int COLOR_BITS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    visible,
  input  logic                    hsync,
  input  logic                    vsync,
  output logic                    rd_req,
  output logic [ADDR_BITS-1:0]    rd_addr,
  input  logic                    rd_ready,
  input  logic                    rd_data_valid,
  input  logic [3*COLOR_BITS-1:0] rd_data,
  output logic [COLOR_BITS-1:0]   vga_red,
  output logic [COLOR_BITS-1:0]   vga_green,
  output logic [COLOR_BITS-1:0]   vga_blue,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 3 * COLOR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [CW:0]          DEPTH_W   = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_WAIT_FRAME, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic                 vsync_q, vsync_d;
  logic [DW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_req_q, rd_req_d;
  logic [DW-1:0]        pix_q, pix_d;
  logic                 hs_out_q, hs_out_d, vs_out_q, vs_out_d;
  logic                 underflow_q, underflow_d;

  logic                 fs, accept, resp, discard, push, pop;
  logic [CW:0]          credit_sum;

  always_comb begin
    fs      = vsync_q && !vsync;
    accept  = rd_req_q && rd_ready;
    // Responses before the first frame start cannot belong to this block's requests.
    resp    = rd_data_valid && (state_q == ST_RUN);
    discard = resp && (drop_q != '0);
    push    = resp && !discard && !fs;
    pop     = visible && (count_q != '0) && !fs;

    state_d  = fs ? ST_RUN : state_q;
    vsync_d  = vsync;
    hs_out_d = hsync;
    vs_out_d = vsync;

    outst_d = outst_q + CW'(accept) - CW'(resp);

    if (fs) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_addr_d = '0;
      // Everything still in flight after this cycle belongs to the old frame.
      drop_d    = outst_d;
    end else begin
      wr_ptr_d  = wr_ptr_q + PW'(push);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      count_d   = count_q + CW'(push) - CW'(pop);
      drop_d    = drop_q - CW'(discard);
      if (accept) begin
        rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
      end else begin
        rd_addr_d = rd_addr_q;
      end
    end

    // FIFO slots already spoken for (filled or in flight) bound new requests.
    credit_sum = {1'b0, count_d} + {1'b0, outst_d};
    rd_req_d   = (state_d == ST_RUN) && (credit_sum < DEPTH_W);

    pix_d       = pop ? mem_q[rd_ptr_q] : '0;
    underflow_d = fs ? 1'b0 : (underflow_q | (visible && (count_q == '0)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WAIT_FRAME;
      vsync_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      rd_addr_q   <= '0;
      rd_req_q    <= 1'b0;
      pix_q       <= '0;
      hs_out_q    <= 1'b1;
      vs_out_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      rd_addr_q   <= rd_addr_d;
      rd_req_q    <= rd_req_d;
      pix_q       <= pix_d;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rd_data;
    end
    if (reset && push && !pop) begin
      assert (count_q != CW'(FIFO_DEPTH));
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign vga_red   = pix_q[DW-1 -: COLOR_BITS];
  assign vga_green = pix_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_blue  = pix_q[COLOR_BITS-1:0];
  assign vga_hsync = hs_out_q;
  assign vga_vsync = vs_out_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// tb_vga_fb_display
//   Drives a reduced-size beam timing and a framebuffer read port with
//   configurable latency, and checks vga_fb_display against a transaction-level
//   model (queues of in-flight requests and buffered pixels).
module tb_vga_fb_display;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 6,  VF = 1, VS = 1, VB = 1, VT = VV + VF + VS + VB;
  localparam int NPIX = HV * VV;
  localparam int FRAME = HT * VT;
  localparam int AB = 7, CB = 4, D = 8, DW = 3 * CB;

  logic clk = 1'b0;
  logic reset;
  logic visible, hsync, vsync;
  logic rd_req, rd_ready, rd_data_valid;
  logic [AB-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [CB-1:0] vga_red, vga_green, vga_blue;
  logic vga_hsync, vga_vsync, underflow;

  vga_fb_display #(
    .H_VISIBLE(HV), .V_VISIBLE(VV), .ADDR_BITS(AB), .COLOR_BITS(CB), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .visible(visible), .hsync(hsync), .vsync(vsync),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int due;
    bit stale;
  } req_t;

  req_t          mem_q[$];
  logic [DW-1:0] m_fifo[$];
  int tests = 0, fails = 0, cyc = 0;

  bit            m_run, m_vs_prev, exp_uf, exp_h, exp_v, exp_req;
  logic [DW-1:0] exp_col;
  int            exp_addr, pop_idx, last_due, last_acc, m_dropped;
  int            lat = 2;
  bit            lat_rand = 0;
  int            rdy_mode = 0;
  int            hc, vc;

  logic [DW-1:0] cap [NPIX];
  int            p_pos;
  bit            p_vis, p_fs, want_first, wrap_seen, uf0, uf_after_fs;
  logic [DW-1:0] first_vis_pix;

  function automatic logic [DW-1:0] pix(input int a);
    return DW'(a * 13 + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    mem_q.delete();
    m_fifo.delete();
    m_run = 0; m_vs_prev = 1; exp_uf = 0; exp_h = 1; exp_v = 1; exp_req = 0;
    exp_col = '0; exp_addr = 0; pop_idx = 0; last_due = 0; last_acc = -1;
    p_pos = -1; p_vis = 0; p_fs = 0;
  endtask

  // Called at a falling clock edge; asserts reset between edges.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    rd_data_valid = 1'b0;
    #1;
    check("rst_rgb", {vga_red, vga_green, vga_blue}, 0);
    check("rst_hsync", vga_hsync, 1);
    check("rst_vsync", vga_vsync, 1);
    check("rst_underflow", underflow, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    reset = 1'b1;
    reset_model();
  endtask

  task automatic step(input logic v, input logic h, input logic s, input logic r, input int pos);
    bit   fs, acc, pop, empty, resp;
    req_t rq;
    int   l;
    logic [DW-1:0] rgb;

    rgb = {vga_red, vga_green, vga_blue};
    check("rgb", rgb, exp_col);
    check("vga_hsync", vga_hsync, exp_h);
    check("vga_vsync", vga_vsync, exp_v);
    check("underflow", underflow, exp_uf);
    check("rd_req", rd_req, exp_req);
    if (exp_req && rd_req) check("rd_addr", rd_addr, exp_addr);
    check("credit", (m_fifo.size() + mem_q.size()) <= D, 1);

    if (p_vis && p_pos >= 0) cap[p_pos] = rgb;
    if (p_vis && p_pos == 0) uf0 = underflow;
    if (p_fs) uf_after_fs = underflow;
    if (want_first && p_vis) begin
      first_vis_pix = rgb;
      want_first = 0;
    end

    visible = v; hsync = h; vsync = s; rd_ready = r;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rd_data_valid = resp;
    rd_data = resp ? pix(mem_q[0].addr) : DW'($urandom);

    fs    = m_vs_prev && !s;
    acc   = rd_req && r;
    empty = (m_fifo.size() == 0);
    pop   = v && !empty && !fs;
    exp_col = pop ? m_fifo[0] : '0;
    exp_uf  = fs ? 1'b0 : (exp_uf | (v & empty));
    if (pop) begin
      check("pix_seq", m_fifo[0], pix(pop_idx % NPIX));
      pop_idx++;
      void'(m_fifo.pop_front());
    end
    if (resp) begin
      rq = mem_q.pop_front();
      if (rq.stale || fs) m_dropped++;
      else m_fifo.push_back(pix(rq.addr));
    end
    if (fs) begin
      foreach (mem_q[i]) mem_q[i].stale = 1;
      m_fifo.delete();
      exp_addr = 0; m_run = 1; pop_idx = 0; want_first = 1;
    end
    if (acc) begin
      l = lat_rand ? int'($urandom_range(1, 4)) : lat;
      rq.addr  = int'(rd_addr);
      rq.due   = (cyc + l > last_due) ? cyc + l : last_due + 1;
      rq.stale = fs;
      last_due = rq.due;
      mem_q.push_back(rq);
      if (last_acc == NPIX - 1 && !fs && rd_addr == 0) wrap_seen = 1;
      last_acc = fs ? -1 : int'(rd_addr);
      if (!fs) exp_addr = (exp_addr + 1) % NPIX;
    end
    exp_h = h; exp_v = s; m_vs_prev = s;
    exp_req = m_run && ((m_fifo.size() + mem_q.size()) < D);
    p_vis = v; p_pos = pos; p_fs = fs;
    @(negedge clk); cyc++;
  endtask

  task automatic run_beam(input int n);
    logic v, h, s, r;
    for (int i = 0; i < n; i++) begin
      v = (hc < HV) && (vc < VV);
      h = !((hc >= HV + HF) && (hc < HV + HF + HS));
      s = !(vc == VV + VF);
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = !((vc >= VV + VF) || (vc == 0));
      endcase
      step(v, h, s, r, v ? vc * HV + hc : -1);
      hc = hc + 1;
      if (hc == HT) begin
        hc = 0;
        vc = (vc + 1 == VT) ? 0 : vc + 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; visible = 0; hsync = 1; vsync = 1;
    rd_ready = 0; rd_data_valid = 0; rd_data = '0;
    want_first = 0; wrap_seen = 0; m_dropped = 0;
    reset_model();
    @(negedge clk);
    do_reset();

    // Full-rate fetch, latency 2, two frames.
    hc = 0; vc = VV; lat = 2; lat_rand = 0; rdy_mode = 0;
    run_beam(FRAME);
    check("f1_first_pix", first_vis_pix, pix(0));
    check("f1_pix_0_0", cap[0], pix(0));
    check("f1_pix_15_0", cap[15], pix(15));
    check("f1_pix_0_1", cap[16], pix(16));
    check("f1_pix_last", cap[NPIX-1], pix(NPIX-1));
    check("f1_no_underflow", underflow, 0);
    foreach (cap[i]) cap[i] = '1;
    run_beam(FRAME);
    check("addr_wrap", wrap_seen, 1);
    check("f2_first_pix", first_vis_pix, pix(0));
    check("f2_pix_0_0", cap[0], pix(0));
    check("f2_no_underflow", underflow, 0);

    // Starved row 0.
    rdy_mode = 2;
    run_beam(FRAME);
    check("starve_pix_0_0", cap[0], 0);
    check("starve_pix_15_0", cap[15], 0);
    check("starve_uf_first", uf0, 1);
    check("starve_uf_sticky", underflow, 1);
    rdy_mode = 0;
    run_beam(FRAME);
    check("uf_clear_on_fs", uf_after_fs, 0);
    check("recover_pix_0_0", cap[0], pix(0));

    // Frame start with five requests in flight, latency 6.
    do_reset();
    lat = 6;
    step(0, 1, 1, 1, -1);
    step(0, 1, 1, 1, -1);
    step(0, 1, 0, 1, -1);
    for (int i = 0; i < 20 && mem_q.size() != 5; i++) step(0, 1, 1, 1, -1);
    check("pending_5", mem_q.size(), 5);
    m_dropped = 0;
    step(0, 1, 0, 0, -1);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 1, -1);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 1, -1);
    step(0, 1, 1, 1, -1);
    step(0, 1, 1, 1, -1);
    check("dropped_5", m_dropped, 5);
    check("realign_first_pix", first_vis_pix, pix(0));

    // Random ready and latency, with a reset pulse in the middle of a line.
    do_reset();
    lat_rand = 1; rdy_mode = 1; hc = 0; vc = VV;
    run_beam(FRAME + 2 * HT + 5);
    do_reset();
    run_beam(3 * FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
